// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared types and sizes for the async FIFO read-side stream adapter.
// Build option: RD_ADAPT_STATS_EN adds the delivered-word counter.
package fifo_rd_stream_adapter_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int ADDR_WIDTH    = 4;
    localparam int RD_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } rd_adapt_state_t;

    function automatic logic [1:0] occ_of(input rd_adapt_state_t s);
        logic [1:0] n;
        n = 2'd0;
        unique case (s)
            S_ONE:   n = 2'd1;
            S_TWO:   n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_skid.sv
// Two-entry skid buffer with occupancy FSM; head entry drives the stream.
module rd_skid_buf #(
    parameter int W = fifo_rd_stream_adapter_pkg::DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   occ
);
    import fifo_rd_stream_adapter_pkg::*;

    rd_adapt_state_t state;
    logic [W-1:0]    tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            dout  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (push) begin
                        dout  <= din;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    // push with pop replaces the head in place
                    if (push && pop) begin
                        dout <= din;
                    end else if (push) begin
                        tail  <= din;
                        state <= S_TWO;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        dout  <= tail;
                        state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign valid = (state != S_EMPTY);
    assign occ   = occ_of(state);

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Async FIFO read-side engine: issues r_en, streams words out via a skid buffer.
// Build option: RD_ADAPT_STATS_EN adds the rd_count port.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = fifo_rd_stream_adapter_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  rrst,
    input  logic                  f_empty,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  r_en,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef RD_ADAPT_STATS_EN
    output logic [CNT_WIDTH-1:0]  rd_count,
`endif
    input  logic                  out_ready
);
    import fifo_rd_stream_adapter_pkg::*;

    logic       inflight;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] level;

    assign pop = out_valid & out_ready;

    // Words held plus word arriving, minus the one leaving this cycle
    assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign r_en  = !f_empty && !rrst && (level < 3'(RD_SKID_DEPTH));

    always_ff @(posedge r_clk) begin
        if (rrst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= r_en;
        end
    end

    rd_skid_buf #(
        .W (DATA_WIDTH)
    ) u_skid (
        .clk   (r_clk),
        .rst   (rrst),
        .push  (inflight),
        .pop   (pop),
        .din   (mem_data_out),
        .dout  (out_data),
        .valid (out_valid),
        .occ   (occ)
    );

`ifdef RD_ADAPT_STATS_EN
    always_ff @(posedge r_clk) begin
        if (rrst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end
`endif

endmodule
